counter_updown: RTL and testbench



---
 rtl/counter_updown_if.sv | 27 ++
 rtl/counter_updown.sv | 119 +++++++++++
 tb/tb_counter_updown.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_if.sv
// Command and status bundle for counter_updown.
// master drives commands and observes the count; slave is the counter.
interface counter_updown_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             incr;
  logic             decr;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_reg;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  logic             dir_up;

  modport master (
    output clr, load, load_val, incr, decr, step,
    input  count_reg, at_max, at_min, wrap, dir_up
  );

  modport slave (
    input  clr, load, load_val, incr, decr, step,
    output count_reg, at_max, at_min, wrap, dir_up
  );
endinterface

// File: rtl/counter_updown.sv
// Up/down counter with programmable modulus and step,
// wrap or saturate at the limits, registered wrap/direction flags.
module counter_updown #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  counter_updown_if.slave  bus
);

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MAX + 1);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] stp_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] ld_ext;
  logic [WIDTH:0] sum;
  logic           do_clr;
  logic           do_load;
  logic           do_up;
  logic           do_dn;

  assign cnt_ext = {1'b0, count_q};
  assign stp_ext = {1'b0, bus.step};
  assign ld_ext  = {1'b0, bus.load_val};
  assign s_ext   = (stp_ext > MAX_W) ? MAX_W : stp_ext;
  assign sum     = cnt_ext + s_ext;

  // Mutually exclusive command selects: clr > load > up/down.
  assign do_clr  = bus.clr;
  assign do_load = bus.load & ~bus.clr;
  assign do_up   = bus.incr & ~bus.decr
                 & ~bus.load & ~bus.clr;
  assign do_dn   = bus.decr & ~bus.incr
                 & ~bus.load & ~bus.clr;

  // Next count, wrap pulse and direction of last limit event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    unique case (1'b1)
      do_clr: begin
        count_d = '0;
      end
      do_load: begin
        if (ld_ext > MAX_W)
          count_d = MAX_N;
        else
          count_d = bus.load_val;
      end
      do_up: begin
        if (sum > MAX_W) begin
          if (SATURATE != 0) begin
            count_d = MAX_N;
            if (count_q != MAX_N) begin
              wrap_d = 1'b1;
              dir_d  = 1'b1;
            end
          end else begin
            count_d = WIDTH'(sum - MOD_W);
            wrap_d  = 1'b1;
            dir_d   = 1'b1;
          end
        end else begin
          count_d = WIDTH'(sum);
        end
      end
      do_dn: begin
        if (cnt_ext < s_ext) begin
          if (SATURATE != 0) begin
            count_d = '0;
            if (count_q != '0) begin
              wrap_d = 1'b1;
              dir_d  = 1'b0;
            end
          end else begin
            count_d = WIDTH'(cnt_ext + MOD_W - s_ext);
            wrap_d  = 1'b1;
            dir_d   = 1'b0;
          end
        end else begin
          count_d = WIDTH'(cnt_ext - s_ext);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.count_reg = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.dir_up    = dir_q;
  assign bus.at_max    = (count_q == MAX_N);
  assign bus.at_min    = (count_q == '0);

endmodule

// File: tb/tb_counter_updown.sv
// Scoreboard bench for counter_updown: decade wrap,
// decade saturate and default-width instances.
module tb_counter_updown;

  logic clk;
  logic rst;

  logic [2:0] clr_v;
  logic [2:0] load_v;
  logic [2:0] incr_v;
  logic [2:0] decr_v;
  logic [7:0] lv_v [3];
  logic [7:0] st_v [3];

  counter_updown_if #(.WIDTH(4)) ifa ();
  counter_updown_if #(.WIDTH(4)) ifb ();
  counter_updown_if #(.WIDTH(8)) ifc ();

  assign ifa.clr      = clr_v[0];
  assign ifa.load     = load_v[0];
  assign ifa.incr     = incr_v[0];
  assign ifa.decr     = decr_v[0];
  assign ifa.load_val = lv_v[0][3:0];
  assign ifa.step     = st_v[0][3:0];

  assign ifb.clr      = clr_v[1];
  assign ifb.load     = load_v[1];
  assign ifb.incr     = incr_v[1];
  assign ifb.decr     = decr_v[1];
  assign ifb.load_val = lv_v[1][3:0];
  assign ifb.step     = st_v[1][3:0];

  assign ifc.clr      = clr_v[2];
  assign ifc.load     = load_v[2];
  assign ifc.incr     = incr_v[2];
  assign ifc.decr     = decr_v[2];
  assign ifc.load_val = lv_v[2];
  assign ifc.step     = st_v[2];

  counter_updown #(.WIDTH(4), .MAX(9), .SATURATE(0)) ua (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  counter_updown #(.WIDTH(4), .MAX(9), .SATURATE(1)) ub (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  counter_updown #(.WIDTH(8)) uc (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  typedef struct {
    int    d;
    int    cyc;
    int    cnt;
    bit    w;
    bit    dir;
    string nm;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   maxv [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e);
    int a_cnt;
    bit a_w, a_dir, a_mx, a_mn, e_mx, e_mn;
    case (e.d)
      0: begin
        a_cnt = int'(ifa.count_reg); a_w = ifa.wrap;
        a_dir = ifa.dir_up; a_mx = ifa.at_max; a_mn = ifa.at_min;
      end
      1: begin
        a_cnt = int'(ifb.count_reg); a_w = ifb.wrap;
        a_dir = ifb.dir_up; a_mx = ifb.at_max; a_mn = ifb.at_min;
      end
      default: begin
        a_cnt = int'(ifc.count_reg); a_w = ifc.wrap;
        a_dir = ifc.dir_up; a_mx = ifc.at_max; a_mn = ifc.at_min;
      end
    endcase
    e_mx = (e.cnt == maxv[e.d]);
    e_mn = (e.cnt == 0);
    total++;
    if (a_cnt !== e.cnt || a_w !== e.w || a_dir !== e.dir ||
        a_mx !== e_mx || a_mn !== e_mn) begin
      bad++;
      $display("FAIL %s dut%0d: got cnt=%0d wrap=%0b dir=%0b max=%0b min=%0b want cnt=%0d wrap=%0b dir=%0b max=%0b min=%0b",
               e.nm, e.d, a_cnt, a_w, a_dir, a_mx, a_mn,
               e.cnt, e.w, e.dir, e_mx, e_mn);
    end
  endtask

  // Monitor: compare each expectation once its edge has happened.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      check(q.pop_front());
    end
  end

  task automatic check_now(input int d, input int cnt,
                           input bit w, input bit dir,
                           input string nm);
    exp_t e;
    e.d = d; e.cyc = 0; e.cnt = cnt;
    e.w = w; e.dir = dir; e.nm = nm;
    check(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    clr_v = '0; load_v = '0; incr_v = '0; decr_v = '0;
    for (int k = 0; k < 3; k++) begin
      lv_v[k] = '0;
      st_v[k] = '0;
    end
  endtask

  task automatic cmd(input int d, input bit c, input bit l,
                     input int lv, input bit i, input bit dc,
                     input int st, input int ecnt, input bit ew,
                     input bit edir, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    clr_v[d]  = c;
    load_v[d] = l;
    incr_v[d] = i;
    decr_v[d] = dc;
    lv_v[d]   = 8'(lv);
    st_v[d]   = 8'(st);
    e.d = d; e.cyc = cyc + 1; e.cnt = ecnt;
    e.w = ew; e.dir = edir; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    maxv[0] = 9; maxv[1] = 9; maxv[2] = 255;
    clr_v = '0; load_v = '0; incr_v = '0; decr_v = '0;
    for (int k = 0; k < 3; k++) begin
      lv_v[k] = '0;
      st_v[k] = '0;
    end
    rst = 1'b0;
    #3;
    check_now(0, 0, 0, 0, "rst_a");
    check_now(1, 0, 0, 0, "rst_b");
    check_now(2, 0, 0, 0, "rst_c");
    #20;
    rst = 1'b1;

    // Count up after reset release.
    cmd(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "up1");
    cmd(0, 0, 0, 0, 1, 0, 1, 2, 0, 0, "up2");
    cmd(0, 0, 0, 0, 1, 0, 1, 3, 0, 0, "up3");
    idle();
    drain();
    #2;
    rst = 1'b0;
    #1;
    check_now(0, 0, 0, 0, "async_rst");
    #3;
    rst = 1'b1;

    // Decade wrap, step 1.
    for (int k = 1; k <= 12; k++) begin
      cmd(0, 0, 0, 0, 1, 0, 1, k % 10, k == 10, k >= 10, "decade");
    end

    // Down wrap with step 3.
    cmd(0, 0, 1, 2, 0, 0, 0, 2, 0, 1, "load2");
    cmd(0, 0, 0, 0, 0, 1, 3, 9, 1, 0, "dn_wrap");
    cmd(0, 0, 0, 0, 0, 1, 3, 6, 0, 0, "dn_nowrap");

    // Priority and collisions.
    cmd(0, 1, 1, 5, 1, 0, 1, 0, 0, 0, "clr_prio");
    cmd(0, 0, 1, 14, 0, 0, 0, 9, 0, 0, "load_clamp");
    cmd(0, 0, 0, 0, 1, 1, 1, 9, 0, 0, "incr_decr");
    cmd(0, 0, 0, 0, 1, 0, 0, 9, 0, 0, "step0");
    idle();
    drain();

    // Saturating instance.
    cmd(1, 0, 1, 8, 0, 0, 0, 8, 0, 0, "sat_load8");
    cmd(1, 0, 0, 0, 1, 0, 5, 9, 1, 1, "sat_up");
    cmd(1, 0, 0, 0, 1, 0, 5, 9, 0, 1, "sat_hold");
    cmd(1, 0, 0, 0, 0, 1, 1, 8, 0, 1, "sat_dn1");
    cmd(1, 0, 0, 0, 0, 1, 15, 0, 1, 0, "sat_dn");
    cmd(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, "sat_floor");
    idle();
    drain();

    // Default parameters, 8-bit full range.
    cmd(2, 0, 1, 250, 0, 0, 0, 250, 0, 0, "c_load");
    cmd(2, 0, 0, 0, 1, 0, 10, 4, 1, 1, "c_up_wrap");
    cmd(2, 0, 0, 0, 0, 1, 5, 255, 1, 0, "c_dn_wrap");
    cmd(2, 0, 0, 0, 0, 0, 5, 255, 0, 0, "c_hold");
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
